// File: rtl/display_scan_if.sv
// Pin bundle between the score logic and the 7-segment scanner.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   ct;
    logic [7:0]              seg;
    logic                    frame_done;

    modport master (output en, value, dp, input ct, seg, frame_done);
    modport slave  (input en, value, dp, output ct, seg, frame_done);
endinterface

// File: rtl/display_scan.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with registered outputs.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module display_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    display_scan_if.slave bus
);
    localparam int MAX_PHASE = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_PHASE + 1);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [7:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    typedef enum logic {ST_SHOW, ST_BLANK} state_t;

    state_t                  r_state;
    logic [DW-1:0]           r_digit;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_snap_val;
    logic [NUM_DIGITS-1:0]   r_snap_dp;
    logic                    r_started;
    logic [NUM_DIGITS-1:0]   r_ct;
    logic [7:0]              r_seg;
    logic                    r_frame_done;

    logic                    w_frame_start;
    logic [4*NUM_DIGITS-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [3:0]              w_nib;
    logic [7:0]              w_seg_on;
    logic [7:0]              w_seg_drv;
    logic [NUM_DIGITS-1:0]   w_ct_on;
    logic [DW-1:0]           w_digit_next;
    logic                    w_dark;

    function automatic logic [6:0] font7(input logic [3:0] n);
        case (n)
            4'h0: font7 = 7'h3F;  4'h1: font7 = 7'h06;  4'h2: font7 = 7'h5B;  4'h3: font7 = 7'h4F;
            4'h4: font7 = 7'h66;  4'h5: font7 = 7'h6D;  4'h6: font7 = 7'h7D;  4'h7: font7 = 7'h07;
            4'h8: font7 = 7'h7F;  4'h9: font7 = 7'h6F;  4'hA: font7 = 7'h77;  4'hB: font7 = 7'h7C;
            4'hC: font7 = 7'h39;  4'hD: font7 = 7'h5E;  4'hE: font7 = 7'h79;  default: font7 = 7'h71;
        endcase
    endfunction

    // The frame-start cycle uses the live inputs so digit 0 already shows the fresh sample.
    assign w_frame_start = bus.en && (r_state == ST_SHOW) && (r_digit == '0) && (r_cnt == '0);
    assign w_val         = w_frame_start ? bus.value : r_snap_val;
    assign w_dp          = w_frame_start ? bus.dp    : r_snap_dp;
    assign w_nib         = w_val[4*r_digit +: 4];
    assign w_seg_on      = {w_dp[r_digit], font7(w_nib)};
    assign w_seg_drv     = SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on;
    assign w_digit_next  = (r_digit == DIGIT_LAST) ? '0 : r_digit + 1'b1;

    always_comb begin
        w_ct_on = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit == DW'(NUM_DIGITS - 1 - int'(i))) w_ct_on[i] = 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lz;
    logic                  w_allz;

    always_comb begin
        w_lz   = '0;
        w_allz = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_allz  = w_allz & (w_val[4*i +: 4] == 4'h0);
            w_lz[i] = w_allz & ~w_dp[i];
        end
    end

    assign w_dark = w_lz[r_digit];
`else
    assign w_dark = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SHOW;
            r_digit      <= '0;
            r_cnt        <= '0;
            r_snap_val   <= '0;
            r_snap_dp    <= '0;
            r_started    <= 1'b0;
            r_ct         <= '1;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_ct         <= '1;
            r_seg        <= SEG_OFF;
            if (bus.en) begin
                if (w_frame_start) begin
                    r_snap_val   <= bus.value;
                    r_snap_dp    <= bus.dp;
                    r_started    <= 1'b1;
                    r_frame_done <= r_started;
                end
                unique case (r_state)
                    ST_SHOW: begin
                        if (!w_dark) begin
                            r_ct  <= w_ct_on;
                            r_seg <= w_seg_drv;
                        end
                        if (r_cnt == DWELL_LAST) begin
                            r_cnt <= '0;
                            if (BLANK_CYCLES > 0) r_state <= ST_BLANK;
                            else                  r_digit <= w_digit_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_SHOW;
                            r_digit <= w_digit_next;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_SHOW;
                endcase
            end
        end
    end

    assign bus.ct         = r_ct;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: DUT A has a blank phase, DUT B has none.
module tb_display_scan;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    display_scan_if #(.NUM_DIGITS(4)) a_if ();
    display_scan_if #(.NUM_DIGITS(4)) b_if ();

    display_scan #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1))
        u_dut_a (.clk(clk), .reset(rst), .bus(a_if));
    display_scan #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1))
        u_dut_b (.clk(clk), .reset(rst), .bus(b_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit use_b, input logic [3:0] ct_e, input logic [7:0] seg_e,
                        input logic fd_e, input string tag);
        logic [3:0] g_ct;
        logic [7:0] g_seg;
        logic       g_fd;
        @(posedge clk);
        @(negedge clk);
        g_ct  = use_b ? b_if.ct  : a_if.ct;
        g_seg = use_b ? b_if.seg : a_if.seg;
        g_fd  = use_b ? b_if.frame_done : a_if.frame_done;
        check({tag, "/ct"},  32'(g_ct),  32'(ct_e));
        check({tag, "/seg"}, 32'(g_seg), 32'(seg_e));
        check({tag, "/fd"},  32'(g_fd),  32'(fd_e));
    endtask

    task automatic show_digit(input bit use_b, input logic [3:0] ct_e, input logic [7:0] seg_e,
                              input logic fd_first, input int nblank, input string tag);
        for (int i = 0; i < 3; i++) step(use_b, ct_e, seg_e, (i == 0) ? fd_first : 1'b0, tag);
        for (int i = 0; i < nblank; i++) step(use_b, 4'hF, 8'hFF, 1'b0, {tag, "_blank"});
    endtask

    initial begin
        rst = 1'b1;
        a_if.en = 1'b1; a_if.value = 16'h1234; a_if.dp = 4'b0000;
        b_if.en = 1'b1; b_if.value = 16'h0008; b_if.dp = 4'b0001;
        repeat (2) @(negedge clk);
        check("rst/ct",  32'(a_if.ct),  32'h0000000F);
        check("rst/seg", 32'(a_if.seg), 32'h000000FF);
        check("rst/fd",  32'(a_if.frame_done), 32'h0);
        rst = 1'b0;

        // frame 1 of 16'h1234; input changed mid-frame must not show
        show_digit(0, 4'b0111, 8'h99, 1'b0, 1, "f1_d0");
        a_if.value = 16'hFFFF;
        show_digit(0, 4'b1011, 8'hB0, 1'b0, 1, "f1_d1");
        show_digit(0, 4'b1101, 8'hA4, 1'b0, 1, "f1_d2");
        show_digit(0, 4'b1110, 8'hF9, 1'b0, 1, "f1_d3");

        // frame 2 shows the FFFF sample
        show_digit(0, 4'b0111, 8'h8E, 1'b1, 1, "f2_d0");
        show_digit(0, 4'b1011, 8'h8E, 1'b0, 1, "f2_d1");

        // enable dropped while digit 2 sits at count 1
        step(0, 4'b1101, 8'h8E, 1'b0, "en_c0");
        a_if.en = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 4'hF, 8'hFF, 1'b0, "en_off");
        a_if.en = 1'b1;
        step(0, 4'b1101, 8'h8E, 1'b0, "en_c1");
        step(0, 4'b1101, 8'h8E, 1'b0, "en_c2");
        step(0, 4'hF, 8'hFF, 1'b0, "en_blank");
        step(0, 4'b1110, 8'h8E, 1'b0, "f2_d3");

        // asynchronous reset mid digit 3
        #2 rst = 1'b1;
        #1;
        check("arst/ct",  32'(a_if.ct),  32'h0000000F);
        check("arst/seg", 32'(a_if.seg), 32'h000000FF);
        check("arst/fd",  32'(a_if.frame_done), 32'h0);
        a_if.value = 16'h5A0C;
        @(negedge clk);
        rst = 1'b0;
        show_digit(0, 4'b0111, 8'hC6, 1'b0, 1, "r_d0");
        show_digit(0, 4'b1011, 8'hC0, 1'b0, 1, "r_d1");
        show_digit(0, 4'b1101, 8'h88, 1'b0, 1, "r_d2");
        show_digit(0, 4'b1110, 8'h92, 1'b0, 1, "r_d3");
        step(0, 4'b0111, 8'hC6, 1'b1, "r_next");

        // no blank phase: 12-cycle frame, '8' with dp on digit 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        show_digit(1, 4'b0111, 8'h00, 1'b0, 0, "b_d0");
        show_digit(1, LZB ? 4'b1111 : 4'b1011, LZB ? 8'hFF : 8'hC0, 1'b0, 0, "b_d1");
        show_digit(1, LZB ? 4'b1111 : 4'b1101, LZB ? 8'hFF : 8'hC0, 1'b0, 0, "b_d2");
        show_digit(1, LZB ? 4'b1111 : 4'b1110, LZB ? 8'hFF : 8'hC0, 1'b0, 0, "b_d3");
        step(1, 4'b0111, 8'h00, 1'b1, "b_next");

`ifdef LEADING_ZERO_BLANK_EN
        a_if.value = 16'h0050;
        a_if.dp    = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        show_digit(0, 4'b0111, 8'hC0, 1'b0, 1, "lz_d0");
        show_digit(0, 4'b1011, 8'h92, 1'b0, 1, "lz_d1");
        show_digit(0, 4'b1111, 8'hFF, 1'b0, 1, "lz_d2");
        show_digit(0, 4'b1111, 8'hFF, 1'b0, 1, "lz_d3");
        step(0, 4'b0111, 8'hC0, 1'b1, "lz_next");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
